hex_display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a shared A-F seven-segment decoder.

---
 rtl/hex_display_scan_ctrl.sv | 109 ++++++++++
 tb/tb_hex_display_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan_ctrl.sv
// hex_display_scan_ctrl: scans an active digit bank onto a shared A-F decoder with blanking gaps;
// host writes land in a shadow bank that is copied to the active bank only at a frame boundary.
module hex_display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 2,
    parameter int DWELL_CYC  = 250,
    parameter int BLANK_CYC  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [3:0]            i_wr_data,
    input  logic                  i_wr_dp,
    input  logic                  i_commit,
    output logic                  o_commit_ack,
    output logic                  o_w,
    output logic                  o_x,
    output logic                  o_y,
    output logic                  o_z,
    output logic                  o_dp_out,
    output logic [NUM_DIGITS-1:0] o_digit_en_n,
    output logic                  o_frame_start
);
    typedef enum logic {BLANK, SHOW} state_t;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int MAX_C = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W = $clog2(MAX_C + 1);

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic [3:0]            r_sh_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [3:0]            r_act_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_act_dp;

    logic             w_blank_end;
    logic             w_show_end;
    logic             w_boundary;
    logic             w_copy;
    logic             w_valid;
    logic             w_dp;
    logic [3:0]       w_code;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_blank_end = (r_state == BLANK) && (r_cnt == CNT_W'(BLANK_CYC - 1));
    assign w_show_end  = (r_state == SHOW) && (r_cnt == CNT_W'(DWELL_CYC - 1));
    assign w_boundary  = w_show_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_copy      = w_boundary && r_pending;
    assign w_state_nxt = w_blank_end ? SHOW : w_show_end ? BLANK : r_state;
    assign w_idx_nxt   = w_boundary ? '0 : w_show_end ? r_idx + 1'b1 : r_idx;
    assign w_cnt_nxt   = (w_blank_end || w_show_end) ? '0 : r_cnt + 1'b1;

    // Outputs are registered from next-cycle state, so the digit being copied in is shown at once.
    always_comb begin
        w_code = 4'h0;
        w_dp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_code = w_copy ? r_sh_code[i] : r_act_code[i];
                w_dp   = w_copy ? r_sh_dp[i] : r_act_dp[i];
            end
        end
    end

    assign w_valid = w_code >= 4'hA;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= BLANK;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_sh_code     <= '{default: 4'h0};
            r_sh_dp       <= '0;
            r_act_code    <= '{default: 4'h0};
            r_act_dp      <= '0;
            o_commit_ack  <= 1'b0;
            {o_w, o_x, o_y, o_z} <= 4'h0;
            o_dp_out      <= 1'b0;
            o_digit_en_n  <= '1;
            o_frame_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pending    <= w_copy ? i_commit : (r_pending | i_commit);
            o_commit_ack <= w_copy;
            if (w_copy) begin
                r_act_code <= r_sh_code;
                r_act_dp   <= r_sh_dp;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i_wr_en && (i_wr_addr == ADDR_W'(i))) begin
                    r_sh_code[i] <= i_wr_data;
                    r_sh_dp[i]   <= i_wr_dp;
                end
            end
            {o_w, o_x, o_y, o_z} <= w_valid ? w_code : 4'h0;
            o_dp_out      <= w_valid & w_dp;
            o_digit_en_n  <= ~(NUM_DIGITS'(w_state_nxt == SHOW && w_valid) << w_idx_nxt);
            o_frame_start <= w_blank_end && (r_idx == '0);
        end
    end
endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// tb_hex_display_scan_ctrl: drives a 4-digit and a 3-digit instance from shared stimulus and
// checks every output each cycle against a frame-position reference model.
module tb_hex_display_scan_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, wr_en, wr_dp, commit;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       ack4, fs4, w4, x4, y4, z4, dp4;
    logic [3:0] en4;
    logic       ack3, fs3, w3, x3, y3, z3, dp3;
    logic [2:0] en3;

    hex_display_scan_ctrl #(.NUM_DIGITS(4), .ADDR_W(2), .DWELL_CYC(250), .BLANK_CYC(8)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_dp(wr_dp), .i_commit(commit), .o_commit_ack(ack4), .o_w(w4), .o_x(x4), .o_y(y4),
        .o_z(z4), .o_dp_out(dp4), .o_digit_en_n(en4), .o_frame_start(fs4));

    hex_display_scan_ctrl #(.NUM_DIGITS(3), .ADDR_W(2), .DWELL_CYC(5), .BLANK_CYC(2)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_dp(wr_dp), .i_commit(commit), .o_commit_ack(ack3), .o_w(w3), .o_x(x3), .o_y(y3),
        .o_z(z3), .o_dp_out(dp3), .o_digit_en_n(en3), .o_frame_start(fs3));

    int n_cmp = 0;
    int n_bad = 0;
    int fs_cnt = 0;
    int ack_cnt = 0;

    int         m_t [2];
    bit         m_pend [2];
    bit         m_ack [2];
    logic [3:0] m_sc [2][16];
    logic [3:0] m_ac [2][16];
    bit         m_sd [2][16];
    bit         m_ad [2][16];

    function automatic int nd(int k); return k ? 3 : 4; endfunction
    function automatic int bc(int k); return k ? 2 : 8; endfunction
    function automatic int dc(int k); return k ? 5 : 250; endfunction
    function automatic int fr(int k); return nd(k) * (bc(k) + dc(k)); endfunction

    // Expected {ack, frame_start, wxyz, dp, en_n} from the position of this cycle inside the frame.
    function automatic logic [10:0] expv(int k);
        int f, dig, pos;
        logic [3:0] c, en;
        logic v;
        f   = m_t[k] % fr(k);
        dig = f / (bc(k) + dc(k));
        pos = f % (bc(k) + dc(k));
        c   = m_ac[k][dig];
        v   = c >= 4'hA;
        en  = 4'hF;
        if (pos >= bc(k) && v) en[dig] = 1'b0;
        return {m_ack[k], f == bc(k), v ? c : 4'h0, v & m_ad[k][dig], en};
    endfunction

    task automatic model(input bit rst, input bit we, input logic [1:0] a, input logic [3:0] d,
                         input bit dp, input bit cm);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k] = 0;
                m_pend[k] = 0;
                m_ack[k] = 0;
                for (int i = 0; i < 16; i++) begin
                    m_sc[k][i] = 4'h0; m_ac[k][i] = 4'h0; m_sd[k][i] = 0; m_ad[k][i] = 0;
                end
            end else begin
                if (m_t[k] % fr(k) == fr(k) - 1 && m_pend[k]) begin
                    for (int i = 0; i < 16; i++) begin
                        m_ac[k][i] = m_sc[k][i]; m_ad[k][i] = m_sd[k][i];
                    end
                    m_ack[k] = 1;
                    m_pend[k] = cm;
                end else begin
                    m_ack[k] = 0;
                    m_pend[k] = m_pend[k] | cm;
                end
                if (we && int'(a) < nd(k)) begin
                    m_sc[k][a] = d; m_sd[k][a] = dp;
                end
                m_t[k]++;
            end
        end
    endtask

    task automatic cmp(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit we, input logic [1:0] a, input logic [3:0] d,
                        input bit dp, input bit cm);
        logic [10:0] o4, o3, e4, e3;
        reset = rst; wr_en = we; wr_addr = a; wr_data = d; wr_dp = dp; commit = cm;
        @(posedge clk);
        model(rst, we, a, d, dp, cm);
        #1;
        o4 = {ack4, fs4, w4, x4, y4, z4, dp4, en4};
        o3 = {ack3, fs3, w3, x3, y3, z3, dp3, 1'b1, en3};
        e4 = expv(0);
        e3 = expv(1);
        fs_cnt += int'(fs4);
        ack_cnt += int'(ack4);
        n_cmp++;
        assert (o4 === e4) else begin
            n_bad++;
            $error("FAIL dut4 t=%0d got %b expected %b", m_t[0], o4, e4);
        end
        n_cmp++;
        assert (o3 === e3) else begin
            n_bad++;
            $error("FAIL dut3 t=%0d got %b expected %b", m_t[1], o3, e3);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 2'd0, 4'h0, 0, 0);
    endtask

    task automatic run_to(input int k, input int target);
        for (int i = 0; i < fr(k) && (m_t[k] % fr(k) != target); i++) idle(1);
    endtask

    initial begin
        // reset, then a blank frame with no acks and one frame_start
        tick(1, 0, 2'd0, 4'h0, 0, 0);
        tick(1, 0, 2'd0, 4'h0, 0, 0);
        fs_cnt = 0; ack_cnt = 0;
        idle(1032);
        cmp("blank_frame_fs", fs_cnt, 1);
        cmp("blank_frame_ack", ack_cnt, 0);
        // A,B,C,F with dp on digit 1, commit alongside the last write
        tick(0, 1, 2'd0, 4'hA, 0, 0);
        tick(0, 1, 2'd1, 4'hB, 1, 0);
        tick(0, 1, 2'd2, 4'hC, 0, 0);
        ack_cnt = 0;
        tick(0, 1, 2'd3, 4'hF, 0, 1);
        idle(2 * 1032);
        cmp("abcf_ack", ack_cnt, 1);
        // non-displayable code in digit 2
        tick(0, 1, 2'd2, 4'h5, 0, 1);
        idle(2 * 1032);
        // write without commit, then commit exactly in the boundary cycle
        tick(0, 1, 2'd1, 4'hE, 0, 0);
        ack_cnt = 0;
        idle(3 * 1032);
        cmp("no_commit_ack", ack_cnt, 0);
        run_to(0, 1031);
        tick(0, 0, 2'd0, 4'h0, 0, 1);
        idle(1031);
        cmp("boundary_commit_late", ack_cnt, 0);
        idle(1032);
        cmp("boundary_commit_ack", ack_cnt, 1);
        // out-of-range address for the 3-digit instance, plus a write in the boundary cycle
        tick(0, 1, 2'd3, 4'hD, 1, 1);
        idle(2 * 1032);
        run_to(0, 1031);
        tick(0, 1, 2'd0, 4'hB, 0, 1);
        idle(2 * 1032);
        // reset during digit 2 SHOW with a commit pending
        run_to(0, 2 * 258 + 18);
        tick(0, 1, 2'd0, 4'hC, 0, 1);
        idle(5);
        tick(1, 0, 2'd0, 4'h0, 0, 0);
        cmp("reset_en_n", int'(en4), 15);
        ack_cnt = 0;
        idle(3 * 1032);
        cmp("reset_drops_commit", ack_cnt, 0);
        // randomized writes, commits and rare resets
        for (int i = 0; i < 20000; i++) begin
            logic [3:0] d;
            d = ($urandom % 3 != 0) ? 4'(10 + $urandom % 6) : 4'($urandom % 16);
            tick($urandom % 8000 == 0, $urandom % 6 == 0, 2'($urandom % 4), d,
                 1'($urandom % 2), $urandom % 400 == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
